// File: rtl/acionador_irrigacao_if.sv
// ---------------------------------------------------------------------------
// acionador_irrigacao_if
//   Bundle of request and actuator signals between the irrigation decision
//   logic (master) and the actuator driver acionador_irrigacao (slave).
//
//   Requests (master -> slave):
//     Tick            single-cycle timebase enable from the shared prescaler
//     Gotejamento     drip request            (asynchronous source)
//     Aspersao        sprinkler request       (asynchronous source)
//     Alarme          tank alarm              (asynchronous source)
//     Erro            sensor inconsistency    (asynchronous source)
//     ValvulaEntrada  tank fill request       (asynchronous source)
//     LimpaFalha      synchronous pulse clearing FalhaEnchimento
//   Actuators (slave -> master):
//     ValvulaGotejo, ValvulaAspersor, Bomba, ValvulaEntradaOut,
//     FalhaEnchimento (sticky fill-timeout fault), Estado[2:0] (FSM code)
// ---------------------------------------------------------------------------
interface acionador_irrigacao_if;
    logic       Tick;
    logic       Gotejamento;
    logic       Aspersao;
    logic       Alarme;
    logic       Erro;
    logic       ValvulaEntrada;
    logic       LimpaFalha;
    logic       ValvulaGotejo;
    logic       ValvulaAspersor;
    logic       Bomba;
    logic       ValvulaEntradaOut;
    logic       FalhaEnchimento;
    logic [2:0] Estado;

    modport master (
        output Tick, Gotejamento, Aspersao, Alarme, Erro, ValvulaEntrada, LimpaFalha,
        input  ValvulaGotejo, ValvulaAspersor, Bomba, ValvulaEntradaOut,
               FalhaEnchimento, Estado
    );

    modport slave (
        input  Tick, Gotejamento, Aspersao, Alarme, Erro, ValvulaEntrada, LimpaFalha,
        output ValvulaGotejo, ValvulaAspersor, Bomba, ValvulaEntradaOut,
               FalhaEnchimento, Estado
    );
endinterface

// File: rtl/acionador_irrigacao.sv
// ---------------------------------------------------------------------------
// acionador_irrigacao
//   Drives the irrigation actuators (drip valve, sprinkler valve, pump, tank
//   fill valve) from the decision-logic requests. Enforces a minimum on time
//   per irrigation mode, a pause between modes, immediate shutdown on alarm
//   or sensor error, and a fill-valve timeout fault. All timers count Tick.
//
//   Ports:
//     Clock    system clock, rising edge
//     Reset_n  asynchronous active-low reset (all outputs 0, Estado OCIOSO)
//     bus      acionador_irrigacao_if.slave: requests in, actuators out
//
//   Estado codes: OCIOSO=000 GOTEJO=001 ASPERSAO=010 PAUSA=011 BLOQUEIO=100
// ---------------------------------------------------------------------------
module acionador_irrigacao #(
    parameter int TEMPO_MIN_LIGADO    = 8,
    parameter int TEMPO_MIN_DESLIGADO = 4,
    parameter int TIMEOUT_ENCHIMENTO  = 64,
    parameter int CONT_W              = 8
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    acionador_irrigacao_if.slave  bus
);

    localparam logic [2:0] OCIOSO   = 3'b000;
    localparam logic [2:0] GOTEJO   = 3'b001;
    localparam logic [2:0] ASPERSAO = 3'b010;
    localparam logic [2:0] PAUSA    = 3'b011;
    localparam logic [2:0] BLOQUEIO = 3'b100;

    localparam logic [CONT_W-1:0] CNT_MAX = '1;
    localparam logic [CONT_W-1:0] MIN_ON  = CONT_W'(TEMPO_MIN_LIGADO);
    localparam logic [CONT_W-1:0] MIN_OFF = CONT_W'(TEMPO_MIN_DESLIGADO);
    localparam logic [CONT_W-1:0] TIMEOUT = CONT_W'(TIMEOUT_ENCHIMENTO);

    function automatic logic [CONT_W-1:0] sat_inc(input logic [CONT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Synchroniser bit order: {ValvulaEntrada, Erro, Alarme, Aspersao, Gotejamento}
    logic [4:0]        sync1_q, sync1_d;
    logic [4:0]        sync2_q, sync2_d;
    logic [2:0]        estado_q, estado_d;
    logic [CONT_W-1:0] t_q, t_d;
    logic [CONT_W-1:0] f_q, f_d;
    logic              vg_q, vg_d;
    logic              va_q, va_d;
    logic              bomba_q, bomba_d;
    logic              veo_q, veo_d;
    logic              falha_q, falha_d;

    logic              gotejamento_s, aspersao_s, alarme_s, erro_s, valvula_entrada_s;
    logic              bloq;
    logic [CONT_W-1:0] t_cnt;
    logic [CONT_W-1:0] f_inc;

    assign gotejamento_s     = sync2_q[0];
    assign aspersao_s        = sync2_q[1];
    assign alarme_s          = sync2_q[2];
    assign erro_s            = sync2_q[3];
    assign valvula_entrada_s = sync2_q[4];
    assign bloq              = alarme_s | erro_s;

    always_comb begin
        sync1_d = {bus.ValvulaEntrada, bus.Erro, bus.Alarme, bus.Aspersao, bus.Gotejamento};
        sync2_d = sync1_q;
    end

    // Mode FSM. t_cnt includes the Tick of the current cycle, so a mode with
    // a minimum of N Ticks is left on the edge that completes its N-th Tick.
    always_comb begin
        estado_d = estado_q;
        t_cnt    = bus.Tick ? sat_inc(t_q) : t_q;
        case (estado_q)
            OCIOSO: begin
                if (gotejamento_s && !aspersao_s) begin
                    estado_d = GOTEJO;
                end else if (aspersao_s && !gotejamento_s) begin
                    estado_d = ASPERSAO;
                end
            end
            GOTEJO: begin
                if ((t_cnt >= MIN_ON) && (!gotejamento_s || aspersao_s)) begin
                    estado_d = PAUSA;
                end
            end
            ASPERSAO: begin
                if ((t_cnt >= MIN_ON) && (!aspersao_s || gotejamento_s)) begin
                    estado_d = PAUSA;
                end
            end
            PAUSA: begin
                if (t_cnt >= MIN_OFF) begin
                    estado_d = OCIOSO;
                end
            end
            BLOQUEIO: begin
                // Leaving BLOQUEIO goes through PAUSA so the minimum off time
                // is honoured after an alarm; staying is handled by bloq below.
                estado_d = PAUSA;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
        if (bloq) begin
            estado_d = BLOQUEIO;
        end

        t_d = (estado_d != estado_q) ? '0 : t_cnt;

        // Outputs decode from the next state so they switch with Estado.
        vg_d    = (estado_d == GOTEJO);
        va_d    = (estado_d == ASPERSAO);
        bomba_d = vg_d | va_d;
    end

    // Fill-valve supervision. LimpaFalha has priority over a coincident
    // timeout and also restarts the timer, otherwise the saturated count
    // would re-trip the fault on the next Tick.
    always_comb begin
        f_inc   = (veo_q && bus.Tick) ? sat_inc(f_q) : f_q;
        f_d     = f_inc;
        falha_d = falha_q;
        if (bus.LimpaFalha) begin
            f_d     = '0;
            falha_d = 1'b0;
        end else if (!valvula_entrada_s) begin
            f_d     = '0;
        end else if (f_inc >= TIMEOUT) begin
            f_d     = TIMEOUT;
            falha_d = 1'b1;
        end
        veo_d = valvula_entrada_s & ~falha_q & ~erro_s;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            estado_q <= OCIOSO;
            t_q      <= '0;
            f_q      <= '0;
            vg_q     <= 1'b0;
            va_q     <= 1'b0;
            bomba_q  <= 1'b0;
            veo_q    <= 1'b0;
            falha_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            estado_q <= estado_d;
            t_q      <= t_d;
            f_q      <= f_d;
            vg_q     <= vg_d;
            va_q     <= va_d;
            bomba_q  <= bomba_d;
            veo_q    <= veo_d;
            falha_q  <= falha_d;
        end
    end

    assign bus.ValvulaGotejo     = vg_q;
    assign bus.ValvulaAspersor   = va_q;
    assign bus.Bomba             = bomba_q;
    assign bus.ValvulaEntradaOut = veo_q;
    assign bus.FalhaEnchimento   = falha_q;
    assign bus.Estado            = estado_q;

endmodule

// File: tb/tb_acionador_irrigacao.sv
// ---------------------------------------------------------------------------
// tb_acionador_irrigacao
//   Directed scoreboard bench. Each stimulus pushes the output changes it
//   must cause (cycle of change, new output vector) into a queue; a monitor
//   on the falling edge pops and compares whenever the output vector changes.
//   Output vector: {Estado[2:0], ValvulaGotejo, ValvulaAspersor, Bomba,
//                   ValvulaEntradaOut, FalhaEnchimento}
// ---------------------------------------------------------------------------
module tb_acionador_irrigacao;

    localparam logic [7:0] V_OCIOSO = 8'b000_000_00;
    localparam logic [7:0] V_GOTEJO = 8'b001_101_00;
    localparam logic [7:0] V_ASPER  = 8'b010_011_00;
    localparam logic [7:0] V_PAUSA  = 8'b011_000_00;
    localparam logic [7:0] V_BLOQ   = 8'b100_000_00;
    localparam logic [7:0] V_VEO    = 8'b000_000_10;
    localparam logic [7:0] V_VEO_F  = 8'b000_000_11;
    localparam logic [7:0] V_F      = 8'b000_000_01;

    typedef struct {
        int         cyc;
        logic [7:0] vec;
    } ev_t;

    logic       Clock = 1'b0;
    logic       Reset_n = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    ev_t        exp_q[$];
    logic [7:0] last_vec = '0;
    logic [7:0] out_vec;

    acionador_irrigacao_if bus();

    acionador_irrigacao dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    assign out_vec = {bus.Estado, bus.ValvulaGotejo, bus.ValvulaAspersor, bus.Bomba,
                      bus.ValvulaEntradaOut, bus.FalhaEnchimento};

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic expect_ev(input int c, input logic [7:0] v);
        ev_t e;
        e.cyc = c;
        e.vec = v;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares each observed output change against the scoreboard.
    always @(negedge Clock) begin
        if (out_vec !== last_vec) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change cyc=%0d actual=%b required=no change", cyc, out_vec);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (out_vec !== e.vec || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL output_event actual=%b@%0d required=%b@%0d",
                             out_vec, cyc, e.vec, e.cyc);
                end
            end
            last_vec = out_vec;
        end
        if (bus.ValvulaGotejo === 1'b1 && bus.ValvulaAspersor === 1'b1) begin
            checks++;
            failures++;
            $display("FAIL valves_exclusive cyc=%0d actual=both high required=at most one", cyc);
        end
    end

    initial begin
        int k;
        int e;
        int n;
        bus.Tick           = 1'b1;
        bus.Gotejamento    = 1'b1;
        bus.Aspersao       = 1'b0;
        bus.Alarme         = 1'b0;
        bus.Erro           = 1'b0;
        bus.ValvulaEntrada = 1'b0;
        bus.LimpaFalha     = 1'b0;
        Reset_n            = 1'b0;

        // Reset with Gotejamento held: everything low; GOTEJO 3 cycles after release.
        step(3);
        check("reset_outputs", out_vec, V_OCIOSO);
        k = cyc;
        expect_ev(k + 3, V_GOTEJO);
        expect_ev(k + 11, V_PAUSA);
        expect_ev(k + 15, V_OCIOSO);
        Reset_n = 1'b1;
        step(1);
        bus.Gotejamento = 1'b0;
        wait_until(k + 20);

        // Short drip pulse: minimum on 8 Ticks, pause 4 Ticks.
        k = cyc;
        e = k + 3;
        expect_ev(e, V_GOTEJO);
        expect_ev(e + 8, V_PAUSA);
        expect_ev(e + 12, V_OCIOSO);
        bus.Gotejamento = 1'b1;
        step(2);
        bus.Gotejamento = 1'b0;
        wait_until(e + 16);

        // Mode change at T=10 passes through PAUSA, then ASPERSAO.
        k = cyc;
        e = k + 3;
        expect_ev(e, V_GOTEJO);
        expect_ev(e + 13, V_PAUSA);
        expect_ev(e + 17, V_OCIOSO);
        expect_ev(e + 18, V_ASPER);
        bus.Gotejamento = 1'b1;
        wait_until(e + 10);
        bus.Gotejamento = 1'b0;
        bus.Aspersao    = 1'b1;

        // Alarm at T=2 in ASPERSAO overrides the minimum on time.
        e = e + 18;
        wait_until(e + 2);
        expect_ev(e + 5, V_BLOQ);
        expect_ev(e + 11, V_PAUSA);
        expect_ev(e + 15, V_OCIOSO);
        bus.Alarme   = 1'b1;
        bus.Aspersao = 1'b0;
        wait_until(e + 8);
        bus.Alarme = 1'b0;
        wait_until(e + 20);

        // Sensor error from OCIOSO also blocks.
        k = cyc;
        expect_ev(k + 3, V_BLOQ);
        expect_ev(k + 6, V_PAUSA);
        expect_ev(k + 10, V_OCIOSO);
        bus.Erro = 1'b1;
        step(3);
        bus.Erro = 1'b0;
        wait_until(k + 14);

        // Fill valve timeout after 64 Ticks, valve closes one cycle later.
        k = cyc;
        expect_ev(k + 3, V_VEO);
        expect_ev(k + 67, V_VEO_F);
        expect_ev(k + 68, V_F);
        bus.ValvulaEntrada = 1'b1;
        wait_until(k + 72);
        check("fault_sticky", out_vec, V_F);

        // LimpaFalha clears the fault and the valve reopens.
        k = cyc;
        expect_ev(k + 1, V_OCIOSO);
        expect_ev(k + 2, V_VEO);
        bus.LimpaFalha = 1'b1;
        step(1);
        bus.LimpaFalha = 1'b0;
        // Clear coinciding with the 64th Tick after reopening: clear wins.
        wait_until(k + 65);
        bus.LimpaFalha = 1'b1;
        step(1);
        bus.LimpaFalha = 1'b0;
        step(1);
        check("clear_beats_timeout", out_vec, V_VEO);
        wait_until(k + 70);
        expect_ev(k + 73, V_OCIOSO);
        bus.ValvulaEntrada = 1'b0;
        wait_until(k + 76);

        // Conflicting requests: stay idle.
        k = cyc;
        bus.Gotejamento = 1'b1;
        bus.Aspersao    = 1'b1;
        wait_until(k + 20);
        check("conflict_idle", out_vec, V_OCIOSO);
        bus.Gotejamento = 1'b0;
        bus.Aspersao    = 1'b0;
        step(5);

        // Reset in GOTEJO clears outputs asynchronously.
        k = cyc;
        expect_ev(k + 3, V_GOTEJO);
        bus.Gotejamento = 1'b1;
        wait_until(k + 5);
        expect_ev(k + 5, V_OCIOSO);
        Reset_n = 1'b0;
        #1;
        check("async_reset", out_vec, V_OCIOSO);
        bus.Gotejamento = 1'b0;
        step(2);
        Reset_n = 1'b1;
        step(8);
        check("after_reset_idle", out_vec, V_OCIOSO);

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_events actual=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/acionador_irrigacao.md
Name: acionador_irrigacao

Overview:
- Downstream of the irrigation decision logic: consumes the Gotejamento, Aspersao, Alarme, Erro and ValvulaEntrada requests and drives the physical actuators (drip valve, sprinkler valve, pump, tank fill valve).
- Enforces minimum on/off times, a dead-time between irrigation modes, immediate shutdown on alarm, and a tank-fill timeout fault.
- All timers count Tick pulses from the shared prescaler.

Parameters:
- TEMPO_MIN_LIGADO, 8, minimum Ticks an irrigation mode stays on once entered.
- TEMPO_MIN_DESLIGADO, 4, Ticks spent in PAUSA before a new mode may start.
- TIMEOUT_ENCHIMENTO, 64, Ticks of continuous fill-valve opening before FalhaEnchimento latches.
- CONT_W, 8, timer width; all timers saturate at 2^CONT_W-1; every other parameter must be ≤ 2^CONT_W-1.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Tick  input  1  single-cycle timebase enable.
- Gotejamento  input  1  drip request, asynchronous source.
- Aspersao  input  1  sprinkler request, asynchronous source.
- Alarme  input  1  tank alarm, asynchronous source.
- Erro  input  1  sensor inconsistency, asynchronous source.
- ValvulaEntrada  input  1  fill request, asynchronous source.
- LimpaFalha  input  1  synchronous pulse that clears FalhaEnchimento.
- ValvulaGotejo  output  1  drip valve drive.
- ValvulaAspersor  output  1  sprinkler valve drive.
- Bomba  output  1  pump drive.
- ValvulaEntradaOut  output  1  fill valve drive.
- FalhaEnchimento  output  1  sticky fill-timeout fault.
- Estado  output  3  FSM state code.

Behaviour:
- Synchronisation: every asynchronous input (Gotejamento, Aspersao, Alarme, Erro, ValvulaEntrada) passes through a 2-flop synchroniser. Synchronised names below carry the suffix _s. Input-to-decision latency is 2 cycles.
- Registered outputs: all outputs are registered. Reset value: every output 0, Estado = OCIOSO (000), all timers 0, synchronisers 0.
- FSM states and codes: OCIOSO=000, GOTEJO=001, ASPERSAO=010, PAUSA=011, BLOQUEIO=100. Codes 101..111 are illegal and recover to OCIOSO on the next clock.
- Output decode:
  - GOTEJO: ValvulaGotejo=1, Bomba=1.
  - ASPERSAO: ValvulaAspersor=1, Bomba=1.
  - All other states: ValvulaGotejo=ValvulaAspersor=Bomba=0.
  - Outputs change on the same clock edge as the state change.
- Timer T: cleared on every state entry, increments on Tick, saturates at 2^CONT_W-1.
- Definition: bloq = Alarme_s | Erro_s. It has highest priority from every state; the next state is BLOQUEIO and minimum-on time is overridden.
- Transitions:
  - OCIOSO: Gotejamento_s & !Aspersao_s → GOTEJO; Aspersao_s & !Gotejamento_s → ASPERSAO. Both asserted is a conflict: stay in OCIOSO.
  - GOTEJO: T ≥ TEMPO_MIN_LIGADO and (!Gotejamento_s or Aspersao_s) → PAUSA. A change of mode always passes through PAUSA; there is no direct GOTEJO↔ASPERSAO transition.
  - ASPERSAO: symmetric to GOTEJO.
  - PAUSA: T ≥ TEMPO_MIN_DESLIGADO → OCIOSO.
  - BLOQUEIO: stay while bloq; when bloq clears → PAUSA, so the minimum-off time is applied after an alarm.
- Fill-valve timer F:
  - F increments on Tick while ValvulaEntradaOut=1; it clears when ValvulaEntrada_s=0.
  - F reaching TIMEOUT_ENCHIMENTO sets FalhaEnchimento and F saturates there.
  - ValvulaEntradaOut = ValvulaEntrada_s & !FalhaEnchimento & !Erro_s, registered.
  - FalhaEnchimento stays set until Reset_n=0 or LimpaFalha=1. If LimpaFalha=1 coincides with the timeout condition, the clear wins and F also clears.
- Reset mid-operation: Reset_n low in any state forces all outputs to 0 immediately (asynchronously). No state is retained.

Test Plan:
- Reset with Gotejamento=1 → all outputs 0, Estado=000. After release, with Tick every cycle: Estado=001, ValvulaGotejo=Bomba=1 three cycles after release (2-cycle sync plus the transition edge).
- Gotejamento pulse lasting 2 Ticks, Tick every cycle → GOTEJO held for exactly 8 Ticks, then PAUSA for 4 Ticks, then OCIOSO. ValvulaGotejo high for 8 cycles.
- In GOTEJO at T=10, switch request to Aspersao → PAUSA with both valves 0 for 4 Ticks, then ASPERSAO with ValvulaAspersor=1. The two valves are never high in the same cycle.
- Alarme asserted in ASPERSAO at T=2 → BLOQUEIO and Bomba=0 three cycles later (minimum-on overridden). Alarme released → PAUSA for 4 Ticks, then OCIOSO.
- ValvulaEntrada held high, Tick every cycle → ValvulaEntradaOut=1, FalhaEnchimento=1 after 64 Ticks, ValvulaEntradaOut=0 one cycle later. LimpaFalha pulse → fault clears and the valve reopens.
- Gotejamento and Aspersao both held high from OCIOSO → Estado stays 000 and all valves stay 0.
